adc_conv_sequencer: RTL and testbench

Conversion sequencer between `adc_spi_slave` and the SAR ADC core. It decodes the SPI control register (enable, start, continuous, averaging) and issues single-cycle start requests to the SAR core. It accumulates and averages 1/2/4/8 conversions and hands the result to the SPI slave with an end-of-conversion pulse. It also returns the hardware clear of the START bit and guards each conversion with a timeout.

---
 rtl/adc_conv_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_adc_conv_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_sequencer.sv
// ---------------------------------------------------------------------------
// adc_conv_sequencer
//
// Purpose: decodes the SPI control register and sequences SAR ADC
// conversions. It averages 1/2/4/8 samples per result, hands each result to
// the SPI slave with an end-of-conversion pulse, clears the START bit in the
// slave when a request is accepted, and guards every conversion with a
// timeout.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_         in   asynchronous reset, active-low
//   ctrl_reg       in   [0] EN, [1] START, [2] CONT, [4:3] AVG (log2 N)
//   hw_clear_start out  1-cycle pulse, clears START in the SPI slave
//   adc_data_out   out  averaged result, held until the next result
//   adc_busy_out   out  high whenever the sequencer is not idle
//   adc_eoc_pulse  out  1-cycle pulse marking a new adc_data_out
//   sar_start      out  1-cycle conversion request to the SAR core
//   sar_busy       in   SAR core busy
//   sar_eoc        in   SAR core done, 1-cycle pulse
//   sar_data       in   SAR result, valid with sar_eoc
//   timeout_err    out  sticky conversion timeout flag
// ---------------------------------------------------------------------------
module adc_conv_sequencer #(
    parameter int WIDTH      = 12,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [WIDTH-1:0] ctrl_reg,
    output logic             hw_clear_start,
    output logic [WIDTH-1:0] adc_data_out,
    output logic             adc_busy_out,
    output logic             adc_eoc_pulse,
    output logic             sar_start,
    input  logic             sar_busy,
    input  logic             sar_eoc,
    input  logic [WIDTH-1:0] sar_data,
    output logic             timeout_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int ACC_W = WIDTH + 3;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Truncating divide by 2^s; the result is the low WIDTH bits.
    function automatic logic [WIDTH-1:0] avg_shift(input logic [ACC_W-1:0] a,
                                                   input logic [1:0]       s);
        logic [ACC_W-1:0] t;
        t = a >> s;
        return t[WIDTH-1:0];
    endfunction

    logic             ctrl_en;
    logic             ctrl_start;
    logic             ctrl_cont;
    logic [1:0]       ctrl_avg;
    logic             ctrl_unused;

    logic [2:0]       state_q,   state_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [3:0]       cnt_q,     cnt_d;
    logic [1:0]       avg_q,     avg_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             eoc_q,     eoc_d;
    logic             err_q,     err_d;

    logic             accept;
    logic             issue;
    logic [ACC_W-1:0] sum;
    logic [3:0]       cnt_inc;
    logic [3:0]       n_samples;

    assign ctrl_en     = ctrl_reg[0];
    assign ctrl_start  = ctrl_reg[1];
    assign ctrl_cont   = ctrl_reg[2];
    assign ctrl_avg    = ctrl_reg[4:3];
    assign ctrl_unused = ^ctrl_reg[WIDTH-1:5];

    assign sum       = acc_q + {3'b000, sar_data};
    assign cnt_inc   = cnt_q + 4'd1;
    assign n_samples = 4'd1 << avg_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        eoc_d     = 1'b0;
        err_d     = err_q;
        accept    = 1'b0;
        issue     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_en && ctrl_start) begin
                    accept  = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    avg_d   = ctrl_avg;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The timeout only starts once the request is actually issued.
                if (!sar_busy) begin
                    issue    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sar_eoc) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_samples) begin
                        // Result and pulse are registered together so they
                        // appear in the DONE cycle.
                        data_d  = avg_shift(sum, avg_q);
                        eoc_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                gap_cnt_d = '0;
                state_d   = (ctrl_cont && ctrl_en) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (ctrl_cont && ctrl_en) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        avg_d   = ctrl_avg;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            avg_q     <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            eoc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            avg_q     <= avg_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            eoc_q     <= eoc_d;
            err_q     <= err_d;
        end
    end

    // The accept decode looks at ctrl_reg directly, so it is masked by reset
    // to keep every output low while reset is held.
    assign hw_clear_start = accept && reset_;
    assign sar_start      = issue;
    assign adc_busy_out   = (state_q != S_IDLE);
    assign adc_data_out   = data_q;
    assign adc_eoc_pulse  = eoc_q;
    assign timeout_err    = err_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
module tb_adc_conv_sequencer;

    localparam int WIDTH   = 12;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 1024;

    logic             clk = 1'b0;
    logic             reset_;
    logic             en, start, cont;
    logic [1:0]       avg;
    logic [WIDTH-1:0] ctrl_reg;
    logic             hw_clear_start;
    logic [WIDTH-1:0] adc_data_out;
    logic             adc_busy_out;
    logic             adc_eoc_pulse;
    logic             sar_start;
    logic             sar_busy;
    logic             sar_eoc;
    logic [WIDTH-1:0] sar_data;
    logic             timeout_err;

    assign ctrl_reg = {{(WIDTH-5){1'b0}}, avg, cont, start, en};

    adc_conv_sequencer #(.WIDTH(WIDTH), .GAP_CYCLES(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_(reset_), .ctrl_reg(ctrl_reg),
        .hw_clear_start(hw_clear_start), .adc_data_out(adc_data_out),
        .adc_busy_out(adc_busy_out), .adc_eoc_pulse(adc_eoc_pulse),
        .sar_start(sar_start), .sar_busy(sar_busy), .sar_eoc(sar_eoc),
        .sar_data(sar_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_hw = 0, n_ss = 0, n_eoc = 0, cyc = 0;
    int last_eoc_cyc = 0;
    bit eoc_seen = 0;
    bit clr = 0;
    bit sar_mute = 0;
    int sar_lat = 5;
    int gaps[$];
    logic [WIDTH-1:0] sar_vals[$];
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_eoc(input int target, input int budget);
        int k = 0;
        while (n_eoc < target && k < budget) begin @(posedge clk); #1; k++; end
        chk("wait_eoc_reached", int'(n_eoc >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (adc_busy_out && k < budget) begin @(posedge clk); #1; k++; end
        chk("wait_idle_reached", int'(!adc_busy_out), 1);
    endtask

    // SPI-slave side: counts pulses, clears START after hw_clear_start,
    // records DONE-to-restart gaps and scores every result.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (hw_clear_start) begin n_hw++; clr = 1; eoc_seen = 0; end
            if (sar_start) begin
                n_ss++;
                if (eoc_seen) begin gaps.push_back(cyc - last_eoc_cyc - 1); eoc_seen = 0; end
            end
            if (adc_eoc_pulse) begin
                n_eoc++;
                last_eoc_cyc = cyc;
                eoc_seen = 1;
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("adc_data_out", int'(adc_data_out), int'(exp_q.pop_front()));
            end
            @(posedge clk); #1;
            if (clr) begin start = 1'b0; clr = 0; end
        end
    endtask

    // SAR core model: answers each sar_start after sar_lat cycles.
    task automatic sar_loop();
        forever begin
            @(negedge clk);
            if (sar_start && !sar_mute) begin
                repeat (sar_lat) @(posedge clk);
                #1;
                sar_eoc  = 1'b1;
                sar_data = (sar_vals.size() != 0) ? sar_vals.pop_front() : '0;
                @(posedge clk); #1;
                sar_eoc  = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hw_clear"}, int'(hw_clear_start), 0);
        chk({tag, "_data"},     int'(adc_data_out),   0);
        chk({tag, "_busy"},     int'(adc_busy_out),   0);
        chk({tag, "_eoc"},      int'(adc_eoc_pulse),  0);
        chk({tag, "_sar_start"},int'(sar_start),      0);
        chk({tag, "_err"},      int'(timeout_err),    0);
    endtask

    initial begin
        int b_hw, b_ss, b_eoc;
        reset_ = 1'b0; en = 0; start = 0; cont = 0; avg = 0;
        sar_busy = 0; sar_eoc = 0; sar_data = '0;
        fork
            monitor_loop();
            sar_loop();
        join_none
        cycles(3);
        check_all_zero("reset");
        reset_ = 1'b1;
        cycles(2);

        // Single conversion, N=1, SAR answers after 20 cycles
        b_hw = n_hw; b_ss = n_ss; b_eoc = n_eoc;
        sar_lat = 20; sar_vals.push_back(12'hABC); exp_q.push_back(12'hABC);
        en = 1; start = 1;
        wait_eoc(b_eoc + 1, 100);
        wait_idle(20);
        cycles(3);
        chk("t1_hw_clear_count", n_hw - b_hw, 1);
        chk("t1_sar_start_count", n_ss - b_ss, 1);
        chk("t1_eoc_count", n_eoc - b_eoc, 1);
        chk("t1_data_held", int'(adc_data_out), 12'hABC);
        chk("t1_busy_low", int'(adc_busy_out), 0);

        // Average of 8: 100..107 sum 828, 828>>3 = 103
        b_ss = n_ss; b_eoc = n_eoc;
        sar_lat = 3;
        for (int i = 100; i < 108; i++) sar_vals.push_back(WIDTH'(i));
        exp_q.push_back(12'd103);
        avg = 2'd3; start = 1;
        wait_eoc(b_eoc + 1, 200);
        wait_idle(20);
        cycles(3);
        chk("t2_sar_start_count", n_ss - b_ss, 8);
        chk("t2_eoc_count", n_eoc - b_eoc, 1);
        chk("t2_data", int'(adc_data_out), 103);

        // Continuous mode, then drop CONT while the 4th conversion is in WAIT
        b_ss = n_ss; b_eoc = n_eoc;
        gaps.delete();
        sar_lat = 5; avg = 2'd0;
        sar_vals.push_back(12'h111); sar_vals.push_back(12'h222);
        sar_vals.push_back(12'h333); sar_vals.push_back(12'h444);
        exp_q.push_back(12'h111); exp_q.push_back(12'h222);
        exp_q.push_back(12'h333); exp_q.push_back(12'h444);
        cont = 1; start = 1;
        wait_eoc(b_eoc + 3, 200);
        begin
            int k = 0;
            while (n_ss < b_ss + 4 && k < 100) begin @(posedge clk); #1; k++; end
            chk("t3_fourth_start", int'(n_ss >= b_ss + 4), 1);
        end
        cont = 0;
        wait_eoc(b_eoc + 4, 100);
        wait_idle(30);
        cycles(40);
        chk("t3_eoc_count", n_eoc - b_eoc, 4);
        chk("t3_sar_start_count", n_ss - b_ss, 4);
        chk("t3_gap_count", gaps.size(), 3);
        foreach (gaps[i]) chk("t3_gap_cycles", gaps[i], GAP);
        chk("t3_busy_low", int'(adc_busy_out), 0);

        // START while the SAR core is busy for 50 cycles
        b_ss = n_ss; b_eoc = n_eoc;
        sar_lat = 2; sar_vals.push_back(12'h123); exp_q.push_back(12'h123);
        sar_busy = 1; start = 1;
        cycles(50);
        chk("t4_no_start_while_busy", n_ss - b_ss, 0);
        chk("t4_busy_out", int'(adc_busy_out), 1);
        sar_busy = 0;
        wait_eoc(b_eoc + 1, 50);
        wait_idle(20);
        chk("t4_sar_start_count", n_ss - b_ss, 1);
        chk("t4_timeout_err", int'(timeout_err), 0);

        // SAR never answers: timeout
        b_eoc = n_eoc;
        sar_mute = 1; start = 1;
        cycles(TIMEOUT + 20);
        chk("t5_timeout_err_set", int'(timeout_err), 1);
        chk("t5_busy_low", int'(adc_busy_out), 0);
        chk("t5_no_eoc", n_eoc - b_eoc, 0);
        chk("t5_data_kept", int'(adc_data_out), 12'h123);
        sar_mute = 0;
        sar_vals.push_back(12'h055); exp_q.push_back(12'h055);
        start = 1;
        cycles(2);
        chk("t5_err_cleared_on_start", int'(timeout_err), 0);
        wait_eoc(b_eoc + 1, 50);
        wait_idle(20);

        // Reset in the middle of WAIT
        b_ss = n_ss;
        sar_lat = 30; sar_vals.push_back(12'hFFF);
        start = 1;
        begin
            int k = 0;
            while (n_ss == b_ss && k < 20) begin @(posedge clk); #1; k++; end
            chk("t6_start_issued", n_ss - b_ss, 1);
        end
        cycles(3);
        chk("t6_busy_before_reset", int'(adc_busy_out), 1);
        reset_ = 1'b0;
        #1;
        check_all_zero("t6_reset");
        cycles(40);
        reset_ = 1'b1;
        cycles(3);
        chk("t6_idle_after_reset", int'(adc_busy_out), 0);

        // START pending while EN=0, accepted once EN is set
        b_hw = n_hw; b_eoc = n_eoc;
        sar_lat = 4;
        en = 0; start = 1;
        cycles(10);
        chk("t7_no_accept_en0", n_hw - b_hw, 0);
        chk("t7_busy_en0", int'(adc_busy_out), 0);
        sar_vals.push_back(12'h321); exp_q.push_back(12'h321);
        en = 1;
        wait_eoc(b_eoc + 1, 50);
        wait_idle(20);
        chk("t7_accept_count", n_hw - b_hw, 1);
        chk("t7_data", int'(adc_data_out), 12'h321);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
